pdm_deserializer: RTL
=====================

// Module: pdm_deserializer
// PURPOSE
//  Receive side of the audio path. Drives the on-board PDM microphone clock and samples its
//  1-bit data stream. Packs 16 consecutive samples, LSB-first, into one word. This matches the
//  bit order the playback serializer shifts out, so a captured word replays bit-identically.
//  Sits between the mic pins and the record-buffer writer; words leave on a valid/ready handshake.
// PARAMETERS
//  CLK_DIV      50   system cycles per m_clk_o half-period (100 MHz / (2*50) = 1 MHz mic clock)
//  WORD_BITS    16   samples per output word
//  LEVEL_THRESH 9    ones-count at or above which level_o asserts (loudness indicator)
// PORTS
//  clock_i      in   1          system clock, 100 MHz, single clock domain
//  reset_n_i    in   1          asynchronous, active-low reset
//  enable_i     in   1          1 = recording state; 0 = idle, mic clock stopped
//  m_data_i     in   1          PDM data from mic (asynchronous to clock_i)
//  m_clk_o      out  1          mic clock
//  m_lr_sel_o   out  1          channel select; constant 0 (left, data valid after rising edge)
//  data_o       out  WORD_BITS  assembled word; stable while valid_o=1
//  valid_o      out  1          word available
//  ready_i      in   1          consumer accepts word when valid_o & ready_i
//  overrun_o    out  1          sticky: a completed word replaced an unaccepted one
//  level_o      out  1          last word's ones-count >= LEVEL_THRESH
// BEHAVIOUR
//  Reset: all outputs 0, including m_clk_o, data_o and m_lr_sel_o. FSM enters IDLE. Divider, bit
//   counter and shift register are cleared. The synchronizer flops are cleared.
//  Input sync: m_data_i passes through 2 flops before use. The 2-cycle delay is far below the
//   half-period, so it is ignored.
//  FSM IDLE: m_clk_o=0, divider=0, bit_cnt=0. If enable_i=1, go to RUN on the next edge.
//  FSM RUN:
//   - Divider counts 0..CLK_DIV-1. At the terminal count it wraps to 0 and m_clk_o toggles.
//   - A sample is taken in the cycle where m_clk_o toggles 1->0 (the falling edge). The
//     synchronized bit shifts into the MSB of the shift register, which shifts right.
//   - bit_cnt counts 0..WORD_BITS-1. On the sample with bit_cnt=WORD_BITS-1, the following
//     happens on the next edge:
//       data_o <= completed word (first sample in bit 0); valid_o <= 1; bit_cnt wraps to 0;
//       level_o <= (popcount(word) >= LEVEL_THRESH).
//   - Popcount is accumulated incrementally per sample: a 5-bit counter, not a combinational
//     adder tree.
//   - enable_i=0 in RUN: go to IDLE next edge. The partial word is discarded, m_clk_o=0,
//     valid_o=0, level_o=0. overrun_o clears. data_o holds its last value.
//  Handshake:
//   - valid_o stays 1 until a cycle with ready_i=1, then drops on the next edge.
//   - ready_i is ignored while valid_o=0.
//   - Completion in the same cycle as acceptance: the new word loads and valid_o stays 1.
//     This is not an overrun.
//   - Completion while valid_o=1 and ready_i=0: the new word overwrites data_o, valid_o stays 1,
//     and overrun_o <= 1. overrun_o is cleared only by enable_i=0 or reset.
//  Word rate: one word per 2*CLK_DIV*WORD_BITS cycles = 1600 cycles at the defaults.
//  Latency: the first word is valid 2*CLK_DIV*WORD_BITS + 1 cycles after leaving IDLE.
//  Reset asserted mid-word: immediate return to reset values, with no partial output.
// STRUCTURE
//  audio_pkg (shared):
//   - typedef logic [15:0] audio_word_t;
//   - localparam AUDIO_CLK_DIV = 50;
//   - enum {IDLE, RUN} pdm_state_t
//  The playback serializer shares the same word type and bit order.
//  Sub-module pdm_clk_gen: divider + m_clk_o + one-cycle fall_strobe output, with reset and
//   enable. Everything else is flat in this module.
// TESTING (CLK_DIV=4 for sim)
//  1. Reset, enable=1, mic model drives 16'hA5C3 LSB-first on m_clk falls, ready_i=1 ->
//     data_o=16'hA5C3, valid_o high 1 cycle, at cycle 2*4*16+1 after leaving IDLE.
//  2. All-ones stream, LEVEL_THRESH=9 -> data_o=16'hFFFF, level_o=1;
//     then all-zeros -> 16'h0000, level_o=0.
//  3. ready_i=0 across two word completions (16'h1234 then 16'h8001) ->
//     data_o=16'h8001, valid_o=1, overrun_o=1; ready_i=1 -> valid_o=0, overrun_o stays 1.
//  4. ready_i=1 exactly in the completion cycle of the second word -> valid_o stays 1,
//     overrun_o=0.
//  5. enable_i=0 after 7 bits, then re-enable and send 16'h00FF ->
//     m_clk_o=0 while disabled; next word is 16'h00FF (no stale bits).
//  6. reset_n_i pulsed low mid-word (asynchronously, between clock edges) ->
//     all outputs 0 immediately; recovery is identical to test 1.

Source files
------------

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared audio-path types and defaults. The record
//                deserializer and the playback serializer both use the
//                same word type and LSB-first bit order.
//  Contents    : audio_word_t, default divider / word size / level threshold,
//                pdm_state_t (IDLE, RUN)
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

  typedef logic [15:0] audio_word_t;

  localparam int AUDIO_CLK_DIV      = 50;
  localparam int AUDIO_WORD_BITS    = 16;
  localparam int AUDIO_LEVEL_THRESH = 9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pdm_state_t;

endpackage
`default_nettype wire

// File: rtl/pdm_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_clk_gen
//  Description : PDM microphone clock generator. A divider counts
//                0..CLK_DIV-1 and the mic clock toggles at each wrap. When a
//                toggle takes the mic clock from 1 to 0, a one-cycle
//                fall strobe is raised in the cycle that follows that edge.
//  Ports       : clk           in   system clock
//                rst_n         in   asynchronous active-low reset
//                i_run         in   1 = run divider, 0 = hold clear (clock 0)
//                o_m_clk       out  mic clock
//                o_fall_strobe out  one-cycle pulse after each falling edge
//  Revision    : 1.0 - initial release
// ============================================================================
module pdm_clk_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = AUDIO_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_m_clk,
  output logic o_fall_strobe
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic             r_m_clk;
  logic             r_fall;
  logic             w_terminal;

  assign w_terminal = (r_div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_m_clk <= 1'b0;
      r_fall  <= 1'b0;
    end else if (!i_run) begin
      r_div   <= '0;
      r_m_clk <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (w_terminal) begin
        r_div   <= '0;
        r_m_clk <= ~r_m_clk;
        // Old value 1 means this toggle is the falling edge.
        r_fall  <= r_m_clk;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_m_clk       = r_m_clk;
  assign o_fall_strobe = r_fall;

endmodule
`default_nettype wire

// File: rtl/pdm_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_deserializer
//  Description : Record side of the audio path. Drives the PDM mic clock,
//                samples the mic data on each falling mic-clock edge, packs
//                WORD_BITS samples LSB-first into a word and hands it out on
//                a valid/ready handshake. Also reports overrun and loudness.
//  Ports       : clock_i    in   system clock
//                reset_n_i  in   asynchronous active-low reset
//                enable_i   in   1 = record, 0 = idle (mic clock stopped)
//                m_data_i   in   PDM data from mic (asynchronous)
//                m_clk_o    out  mic clock
//                m_lr_sel_o out  channel select, tied to 0 (left)
//                data_o     out  assembled word, stable while valid_o=1
//                valid_o    out  word available
//                ready_i    in   consumer accepts when valid_o & ready_i
//                overrun_o  out  sticky: completed word replaced unread one
//                level_o    out  last word's ones-count >= LEVEL_THRESH
//  Revision    : 1.0 - initial release
// ============================================================================
module pdm_deserializer
  import audio_pkg::*;
#(
  parameter int CLK_DIV      = AUDIO_CLK_DIV,
  parameter int WORD_BITS    = AUDIO_WORD_BITS,
  parameter int LEVEL_THRESH = AUDIO_LEVEL_THRESH
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 enable_i,
  input  logic                 m_data_i,
  output logic                 m_clk_o,
  output logic                 m_lr_sel_o,
  output logic [WORD_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 overrun_o,
  output logic                 level_o
);

  localparam int CNT_W  = $clog2(WORD_BITS);
  localparam int ONES_W = $clog2(WORD_BITS + 1);

  // --------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  pdm_state_t r_state;
  pdm_state_t w_state_next;
  logic       w_run;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (enable_i)  w_state_next = RUN;
      RUN:  if (!enable_i) w_state_next = IDLE;
    endcase
  end

  // Gating with enable_i makes the datapath and mic clock clear on the same
  // edge that takes the FSM back to IDLE.
  always_comb begin
    w_run = (r_state == RUN) && enable_i;
  end

  // --------------------------------------------------------------------------
  // Mic clock generator
  // --------------------------------------------------------------------------
  logic w_fall;

  pdm_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk           (clock_i),
    .rst_n         (reset_n_i),
    .i_run         (w_run),
    .o_m_clk       (m_clk_o),
    .o_fall_strobe (w_fall)
  );

  // --------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous mic data
  // --------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= m_data_i;
      r_sync2 <= r_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Shift register, bit counter, running ones-count, output handshake
  // --------------------------------------------------------------------------
  logic [WORD_BITS-1:0] r_shift;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [ONES_W-1:0]    r_ones;
  logic [WORD_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_overrun;
  logic                 r_level;

  logic                 w_sample;
  logic                 w_last;
  logic [WORD_BITS-1:0] w_word;
  logic [ONES_W-1:0]    w_ones_next;

  assign w_sample    = w_run & w_fall;
  assign w_last      = (r_bit_cnt == CNT_W'(WORD_BITS - 1));
  // Shift right, new sample into MSB: first sample lands in bit 0.
  assign w_word      = {r_sync2, r_shift[WORD_BITS-1:1]};
  assign w_ones_next = r_ones + {{(ONES_W-1){1'b0}}, r_sync2};

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_ones    <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_level   <= 1'b0;
    end else if (!w_run) begin
      // Partial word is discarded; data_o keeps its last value.
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_ones    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_level   <= 1'b0;
    end else begin
      if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_sample) begin
        r_shift <= w_word;
        if (w_last) begin
          // Completion overrides the acceptance drop above, so a word
          // accepted in its replacement's completion cycle is not an overrun.
          r_data    <= w_word;
          r_valid   <= 1'b1;
          r_level   <= (w_ones_next >= ONES_W'(LEVEL_THRESH));
          r_bit_cnt <= '0;
          r_ones    <= '0;
          if (r_valid && !ready_i) begin
            r_overrun <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          r_ones    <= w_ones_next;
        end
      end
    end
  end

  assign m_lr_sel_o = 1'b0;
  assign data_o     = r_data;
  assign valid_o    = r_valid;
  assign overrun_o  = r_overrun;
  assign level_o    = r_level;

endmodule
`default_nettype wire
